// File: rtl/ir_sequencer_if.sv
// Bus between the instruction sequencer and the register file, ALU and memory.
interface ir_sequencer_if;
  logic [15:0] MDIN;
  logic        MREADY;
  logic [15:0] IR;
  logic        WED;
  logic        WE7;
  logic        REA;
  logic        REA7;
  logic        REB;
  logic        RED2B;
  logic [2:0]  ALUOP;
  logic [15:0] K;
  logic        DSEL;
  logic        MREQ;
  logic        MWRITE;
  logic        HALTED;

  modport master (
    input  MDIN, MREADY,
    output IR, WED, WE7, REA, REA7, REB, RED2B, ALUOP, K, DSEL, MREQ, MWRITE, HALTED
  );

  modport slave (
    output MDIN, MREADY,
    input  IR, WED, WE7, REA, REA7, REB, RED2B, ALUOP, K, DSEL, MREQ, MWRITE, HALTED
  );
endinterface

// File: rtl/ir_sequencer.sv
// Instruction register plus fetch/execute control sequencer for the 16-bit CPU.
// One instruction in flight at a time: PCINIT -> FETCH -> INCPC -> EXEC -> FETCH ...
module ir_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          CLK,
  input  logic          RESET,
  ir_sequencer_if.master bus
);

  localparam logic [2:0] ST_PCINIT = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_INCPC  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [2:0] OP_ALU   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_JUMP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_INC   = 3'd1;
  localparam logic [2:0] ALU_CONST = 3'd2;
  localparam logic [2:0] ALU_FUNC  = 3'd3;

  logic [2:0]  stateQ, stateD;
  logic [15:0] irQ, irD;
  logic [2:0]  opcode;

  logic wedD, we7D, reaD, rea7D, rebD, red2bD, dselD, mreqD, mwriteD, haltedD;
  logic [2:0] aluopD;

  assign opcode = irQ[15:13];

  // Next-state and IR load: IR only changes on a completed fetch.
  always_comb begin
    stateD = stateQ;
    irD    = irQ;
    case (stateQ)
      ST_PCINIT: stateD = ST_FETCH;
      ST_FETCH: begin
        if (bus.MREADY) begin
          irD    = bus.MDIN;
          stateD = ST_INCPC;
        end
      end
      ST_INCPC: stateD = ST_EXEC;
      ST_EXEC: begin
        case (opcode)
          OP_LOAD, OP_STORE: if (bus.MREADY) stateD = ST_FETCH;
          OP_HALT:           stateD = ST_HALT;
          default:           stateD = ST_FETCH;
        endcase
      end
      ST_HALT: stateD = ST_HALT;
      default: stateD = ST_PCINIT;
    endcase
  end

  // State and instruction registers, cleared asynchronously by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stateQ <= ST_PCINIT;
      irQ    <= 16'h0000;
    end else begin
      stateQ <= stateD;
      irQ    <= irD;
    end
  end

  // Output decode from state and IR; the LOAD write enable alone follows MREADY so D is written on the completing edge.
  always_comb begin
    wedD    = 1'b0;
    we7D    = 1'b0;
    reaD    = 1'b0;
    rea7D   = 1'b0;
    rebD    = 1'b0;
    red2bD  = 1'b0;
    aluopD  = ALU_PASSA;
    dselD   = 1'b0;
    mreqD   = 1'b0;
    mwriteD = 1'b0;
    haltedD = 1'b0;
    case (stateQ)
      ST_PCINIT: begin
        aluopD = ALU_CONST;
        we7D   = 1'b1;
      end
      ST_FETCH: begin
        rea7D = 1'b1;
        mreqD = 1'b1;
      end
      ST_INCPC: begin
        rea7D  = 1'b1;
        aluopD = ALU_INC;
        we7D   = 1'b1;
      end
      ST_EXEC: begin
        case (opcode)
          OP_ALU: begin
            reaD   = 1'b1;
            rebD   = 1'b1;
            aluopD = ALU_FUNC;
            wedD   = 1'b1;
          end
          OP_LOAD: begin
            reaD  = 1'b1;
            mreqD = 1'b1;
            dselD = 1'b1;
            wedD  = bus.MREADY;
          end
          OP_STORE: begin
            reaD    = 1'b1;
            red2bD  = 1'b1;
            mreqD   = 1'b1;
            mwriteD = 1'b1;
          end
          OP_JUMP: begin
            reaD   = 1'b1;
            aluopD = ALU_PASSA;
            we7D   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: haltedD = 1'b1;
      default: ;
    endcase
  end

  // Strobes and the memory request are forced low while RESET is held so an abandoned cycle leaves no write edge.
  always_comb begin
    bus.WED    = wedD    & ~RESET;
    bus.WE7    = we7D    & ~RESET;
    bus.REA    = reaD    & ~RESET;
    bus.REA7   = rea7D   & ~RESET;
    bus.REB    = rebD    & ~RESET;
    bus.RED2B  = red2bD  & ~RESET;
    bus.MREQ   = mreqD   & ~RESET;
    bus.MWRITE = mwriteD & ~RESET;
    bus.HALTED = haltedD & ~RESET;
    bus.DSEL   = dselD;
    bus.ALUOP  = aluopD;
    bus.IR     = irQ;
    bus.K      = RESET_PC;
  end

endmodule
